// File: rtl/ttl_addressable_register_pkg.sv
// rtl/ttl_addressable_register_pkg.sv - mode encoding and 2D bus pack helpers for the addressable register
`ifndef TTL_ADDR_REG_PKG_MACROS
`define TTL_ADDR_REG_PKG_MACROS

`define ASSIGN_PACK(PK_WIDTH, PK_LEN, PK_SRC, PK_DEST) \
   for (genvar pk_idx = 0; pk_idx < (PK_LEN); pk_idx++) begin : g_pack \
      assign PK_DEST[pk_idx*(PK_WIDTH) +: (PK_WIDTH)] = PK_SRC[pk_idx]; \
   end

`define ASSIGN_UNPACK(PK_WIDTH, PK_LEN, PK_SRC, PK_DEST) \
   for (genvar pk_idx = 0; pk_idx < (PK_LEN); pk_idx++) begin : g_unpack \
      assign PK_DEST[pk_idx] = PK_SRC[pk_idx*(PK_WIDTH) +: (PK_WIDTH)]; \
   end

`endif

package ttl_addressable_register_pkg;

   // Encoded as {Clear_bar, Enable_bar}
   typedef enum logic [1:0] {
      MODE_DEMUX       = 2'b00,
      MODE_CLEAR       = 2'b01,
      MODE_ADDRESSABLE = 2'b10,
      MODE_MEMORY      = 2'b11
   } mode_t;

   function automatic mode_t decode_mode(input logic clear_bar, input logic enable_bar);
      return mode_t'({clear_bar, enable_bar});
   endfunction

endpackage

// File: rtl/ttl_addressable_register_slice.sv
// rtl/ttl_addressable_register_slice.sv - one block: WIDTH_OUT storage bits with per-block mode decode
module ttl_addressable_register_slice
   import ttl_addressable_register_pkg::*;
#(
   parameter int WIDTH_OUT    = 8,
   parameter int WIDTH_SELECT = $clog2(WIDTH_OUT)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable_bar,
   input  logic                    clear_bar,
   input  logic [WIDTH_SELECT-1:0] select,
   input  logic                    d,
   output logic [WIDTH_OUT-1:0]    q
);

   mode_t                mode;
   logic [WIDTH_OUT-1:0] hit;
   logic [WIDTH_OUT-1:0] q_next;

   // An out-of-range select decodes to no hit, so nothing is written
   always_comb begin
      hit = '0;
      for (int b = 0; b < WIDTH_OUT; b++) begin
         hit[b] = (select == WIDTH_SELECT'(b));
      end
   end

   always_comb begin
      mode   = decode_mode(clear_bar, enable_bar);
      q_next = q;
      case (mode)
         MODE_ADDRESSABLE: q_next = (q & ~hit) | (hit & {WIDTH_OUT{d}});
         MODE_DEMUX:       q_next = hit & {WIDTH_OUT{d}};
         MODE_CLEAR:       q_next = '0;
         default:          q_next = q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else begin
         q <= q_next;
      end
   end

endmodule

// File: rtl/ttl_addressable_register.sv
// rtl/ttl_addressable_register.sv - clocked addressable register/demux, optional Y readback under TTL_ADDR_REG_READBACK_EN
module ttl_addressable_register
   import ttl_addressable_register_pkg::*;
#(
   parameter int BLOCKS       = 2,
   parameter int WIDTH_OUT    = 8,
   parameter int WIDTH_SELECT = $clog2(WIDTH_OUT),
   parameter int DELAY_RISE   = 0,
   parameter int DELAY_FALL   = 0
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic [BLOCKS-1:0]           Enable_bar,
   input  logic [BLOCKS-1:0]           Clear_bar,
   input  logic [WIDTH_SELECT-1:0]     Select,
   input  logic [BLOCKS-1:0]           D,
`ifdef TTL_ADDR_REG_READBACK_EN
   output logic [BLOCKS-1:0]           Y,
`endif
   output logic [BLOCKS*WIDTH_OUT-1:0] Q_2D
);

   logic [WIDTH_OUT-1:0] q_block [BLOCKS];

   // Propagation delays are zero-time in the netlist; only their sign is checked
   if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
      $error("ttl_addressable_register: negative output delay");
   end

   for (genvar i = 0; i < BLOCKS; i++) begin : g_block
      ttl_addressable_register_slice #(
         .WIDTH_OUT    (WIDTH_OUT),
         .WIDTH_SELECT (WIDTH_SELECT)
      ) u_slice (
         .clk        (Clk),
         .rst        (Reset),
         .enable_bar (Enable_bar[i]),
         .clear_bar  (Clear_bar[i]),
         .select     (Select),
         .d          (D[i]),
         .q          (q_block[i])
      );
   end

   `ASSIGN_PACK(WIDTH_OUT, BLOCKS, q_block, Q_2D)

`ifdef TTL_ADDR_REG_READBACK_EN
   // Readback is gated by the write enable and reads zero for out-of-range select
   always_comb begin
      Y = '0;
      for (int i = 0; i < BLOCKS; i++) begin
         for (int b = 0; b < WIDTH_OUT; b++) begin
            if (!Enable_bar[i] && (Select == WIDTH_SELECT'(b))) begin
               Y[i] = q_block[i][b];
            end
         end
      end
   end
`endif

endmodule
